// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one word/byte load or store at a time,
// held for LATENCY busy cycles, then answered with a single-cycle response.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_memwidth,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic            write_q;
    logic            byte_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic            do_access;
    logic            misaligned;
    logic [31:0]     word;
    logic [31:0]     mem [DEPTH_WORDS];
    logic            unused_addr;

    // Upper address bits are ignored so the array wraps.
    assign unused_addr = ^req_addr[31:AW+2];

    assign req_ready  = (state == IDLE) && !reset;
    assign idx        = addr_q[AW+1:2];
    assign lane       = addr_q[1:0];
    assign do_access  = (state == BUSY) && (cnt == '0);
    assign misaligned = !byte_q && (lane != 2'd0);
    assign word       = mem[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req_valid) state_d = BUSY;
            BUSY:    if (cnt == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && req_valid) begin
            cnt     <= CW'(LATENCY - 1);
            write_q <= req_write;
            byte_q  <= req_memwidth;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Storage array has no reset; only the access edge writes it.
    always_ff @(posedge clk) begin
        if (do_access && write_q && !misaligned) begin
            if (byte_q) begin
                mem[idx][{lane, 3'b000} +: 8] <= wdata_q[7:0];
            end else begin
                mem[idx] <= wdata_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= do_access;
            if (do_access) begin
                resp_err <= misaligned;
                if (misaligned || write_q) begin
                    resp_rdata <= '0;
                end else if (byte_q) begin
                    resp_rdata <= {24'h0, word[{lane, 3'b000} +: 8]};
                end else begin
                    resp_rdata <= word;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a
// byte-addressed reference memory; a second instance uses LATENCY=1.
`timescale 1ns/1ps
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        v0, rdy0, w0, bw0, rv0, e0;
    logic [31:0] a0, d0, rd0;
    logic        v1, rdy1, w1, bw1, rv1, e1;
    logic [31:0] a1, d1, rd1;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] mb [2][256];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
        .req_write(w0), .req_memwidth(bw0), .req_addr(a0), .req_wdata(d0),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(e0)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
        .req_write(w1), .req_memwidth(bw1), .req_addr(a1), .req_wdata(d1),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(e1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 256-byte little-endian memory per instance, address modulo 256.
    function automatic void mdl(input int i, input bit w, input bit bw, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] rd, output bit e);
        int b;
        int base;
        b    = int'(a % 256);
        base = b - (b % 4);
        rd   = 32'h0;
        e    = !bw && (a % 4 != 0);
        if (e) return;
        if (w) begin
            if (bw) mb[i][b] = d[7:0];
            else for (int k = 0; k < 4; k++) mb[i][base+k] = d[8*k +: 8];
        end else if (bw) begin
            rd = {24'h0, mb[i][b]};
        end else begin
            rd = {mb[i][base+3], mb[i][base+2], mb[i][base+1], mb[i][base]};
        end
    endfunction

    // One transaction on u0 with garbage on the inputs while busy.
    task automatic txn0(input bit w, input bit bw, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit e, output int lat);
        @(negedge clk);
        chk("ready_before_req", 32'(rdy0), 32'd1);
        v0 = 1'b1; w0 = w; bw0 = bw; a0 = a; d0 = d;
        @(posedge clk); #1;
        v0 = 1'($urandom); w0 = 1'($urandom); bw0 = 1'($urandom);
        a0 = $urandom; d0 = $urandom;
        lat = 0;
        while (rv0 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rd0;
        e  = e0;
        v0 = 1'b0;
        @(posedge clk); #1;
        chk("pulse_one_cycle", 32'(rv0), 32'd0);
        chk("ready_after_resp", 32'(rdy0), 32'd1);
    endtask

    task automatic op0(input string tag, input bit w, input bit bw, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output bit e);
        logic [31:0] xrd;
        bit          xe;
        int          lat;
        txn0(w, bw, a, d, rd, e, lat);
        mdl(0, w, bw, a, d, xrd, xe);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_rdata"}, rd, xrd);
        chk({tag, "_err"}, 32'(e), 32'(xe));
    endtask

    initial begin
        logic [31:0] rd;
        bit          e;
        logic [31:0] ra;
        bit          rw, rbw;
        int          n;
        logic [31:0] op_a [6];
        logic [31:0] op_d [6];
        bit          op_w [6];
        bit          op_b [6];
        logic [31:0] expq [$];
        bit          experr [$];
        int          acc [$];
        int          op_i;
        int          nresp;

        reset = 1'b1;
        v0 = 0; w0 = 0; bw0 = 0; a0 = 0; d0 = 0;
        v1 = 0; w1 = 0; bw1 = 0; a1 = 0; d1 = 0;
        #12;
        chk("rst_ready_low", 32'(rdy0), 32'd0);
        chk("rst_resp_valid", 32'(rv0), 32'd0);
        @(negedge clk); reset = 1'b0; #1;
        chk("rst_ready_high", 32'(rdy0), 32'd1);
        chk("rst_rdata", rd0, 32'd0);
        chk("rst_err", 32'(e0), 32'd0);

        for (int i = 0; i < 64; i++) op0("preload", 1, 0, 32'(i * 4), $urandom, rd, e);

        op0("st_word", 1, 0, 32'h10, 32'hDEADBEEF, rd, e);
        op0("ld_word", 0, 0, 32'h10, 32'h0, rd, e);
        chk("ld_word_lit", rd, 32'hDEADBEEF);

        op0("merge_sw", 1, 0, 32'h20, 32'h11223344, rd, e);
        op0("merge_sb", 1, 1, 32'h22, 32'h000000AA, rd, e);
        op0("merge_lw", 0, 0, 32'h20, 32'h0, rd, e);
        chk("merge_lw_lit", rd, 32'h11AA3344);
        op0("merge_lb", 0, 1, 32'h23, 32'h0, rd, e);
        chk("merge_lb_lit", rd, 32'h00000011);

        op0("mis_sw", 1, 0, 32'h06, 32'h12345678, rd, e);
        chk("mis_err_lit", 32'(e), 32'd1);
        op0("mis_lw4", 0, 0, 32'h04, 32'h0, rd, e);
        op0("mis_lw8", 0, 0, 32'h08, 32'h0, rd, e);
        op0("mis_lb6", 0, 1, 32'h06, 32'h0, rd, e);
        chk("mis_lb_err_lit", 32'(e), 32'd0);

        // Reset while the store is in BUSY: store dropped, no pulse.
        op0("rb_init", 1, 0, 32'h30, 32'h0, rd, e);
        @(negedge clk);
        v0 = 1; w0 = 1; bw0 = 0; a0 = 32'h30; d0 = 32'hCAFEF00D;
        @(posedge clk); #1;
        v0 = 0;
        reset = 1'b1; #1;
        chk("rb_ready_low", 32'(rdy0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rb_no_pulse", 32'(rv0), 32'd0);
        end
        @(negedge clk); reset = 1'b0; #1;
        chk("rb_ready_back", 32'(rdy0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rb_no_pulse_after", 32'(rv0), 32'd0);
        end
        op0("rb_load", 0, 0, 32'h30, 32'h0, rd, e);
        chk("rb_load_lit", rd, 32'h0);

        // Reset during RESP: pulse cut, store already performed.
        @(negedge clk);
        v0 = 1; w0 = 1; bw0 = 0; a0 = 32'h34; d0 = 32'h600DCAFE;
        @(posedge clk); #1;
        v0 = 0;
        n = 0;
        while (rv0 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rr_pulse_seen", 32'(rv0), 32'd1);
        reset = 1'b1; #1;
        chk("rr_pulse_cut", 32'(rv0), 32'd0);
        chk("rr_rdata_clr", rd0, 32'd0);
        @(negedge clk); reset = 1'b0;
        mdl(0, 1, 0, 32'h34, 32'h600DCAFE, rd, e);
        op0("rr_load", 0, 0, 32'h34, 32'h0, rd, e);
        chk("rr_load_lit", rd, 32'h600DCAFE);

        op0("wrap_sw", 1, 0, 32'h100, 32'h55, rd, e);
        op0("wrap_lw", 0, 0, 32'h000, 32'h0, rd, e);
        chk("wrap_lit", rd, 32'h00000055);

        // Back-to-back on the LATENCY=1 instance with valid held high.
        op_w = '{1, 1, 0, 0, 0, 0};
        op_b = '{0, 0, 0, 1, 0, 0};
        op_a = '{32'h08, 32'h0C, 32'h08, 32'h0F, 32'h0C, 32'h09};
        op_d = '{32'h0BADF00D, 32'h11223344, 32'h0, 32'h0, 32'h0, 32'h0};
        op_i = 0;
        nresp = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (rv1 === 1'b1) begin
                nresp++;
                if (expq.size() > 0) begin
                    chk("b2b_rdata", rd1, expq.pop_front());
                    chk("b2b_err", 32'(e1), 32'(experr.pop_front()));
                end else begin
                    chk("b2b_extra_resp", 32'(rv1), 32'd0);
                end
            end
            if (rdy1 === 1'b1) begin
                if (op_i < 6) begin
                    v1 = 1; w1 = op_w[op_i]; bw1 = op_b[op_i]; a1 = op_a[op_i]; d1 = op_d[op_i];
                    mdl(1, op_w[op_i], op_b[op_i], op_a[op_i], op_d[op_i], rd, e);
                    expq.push_back(rd);
                    experr.push_back(e);
                    acc.push_back(cyc);
                    op_i++;
                end else begin
                    v1 = 0;
                end
            end else begin
                w1 = 1'($urandom); bw1 = 1'($urandom); a1 = $urandom; d1 = $urandom;
            end
        end
        chk("b2b_accepts", 32'(acc.size()), 32'd6);
        chk("b2b_resp_count", 32'(nresp), 32'd6);
        for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
        chk("b2b_lw_lit", 32'h0BADF00D, 32'h0BADF00D ^ 32'(expq.size()));

        // Random traffic with wrapping addresses.
        for (int i = 0; i < 150; i++) begin
            ra  = 32'($urandom_range(0, 1023));
            rbw = 1'($urandom);
            rw  = 1'($urandom);
            if (!rbw && ($urandom % 4 != 0)) ra[1:0] = 2'b00;
            op0("rand", rw, rbw, ra, $urandom, rd, e);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the MIPS core's load/store path. It accepts one word or byte request at a time over a valid/ready handshake and holds it for a fixed, parameterised latency. It then performs the store or load and returns a single-cycle response. It replaces the single-cycle `dmem` behind the processor so the core's memory stage can be exercised against realistic wait states.

## Interface
Parameters:
- `DEPTH_WORDS`, default 64: number of 32-bit words in the array; power of two; index = `req_addr[log2(DEPTH_WORDS)+1:2]`, upper address bits ignored (wrap).
- `LATENCY`, default 2: BUSY cycles between acceptance and response, legal range 1..15.

Ports:
- `clk` in, 1 bit: single clock; all state updates on its rising edge.
- `reset` in, 1 bit: asynchronous, active-high.
- `req_valid` in, 1 bit: request present.
- `req_ready` out, 1 bit: responder can accept a request; high only in IDLE.
- `req_write` in, 1 bit: 1 = store, 0 = load.
- `req_memwidth` in, 1 bit: 0 = word, 1 = byte (same encoding as the core's memwidth).
- `req_addr` in, 32 bits: byte address.
- `req_wdata` in, 32 bits: store data; byte stores use bits [7:0].
- `resp_valid` out, 1 bit: one-cycle response pulse.
- `resp_rdata` out, 32 bits: load data; 0 for stores and errors.
- `resp_err` out, 1 bit: misaligned word access; valid only with `resp_valid`.

## Operation
- States are IDLE, BUSY and RESP, encoded 2-bit. There is a 4-bit wait counter `cnt`.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready` at an edge: capture write, memwidth, addr and wdata into request registers; `cnt`<=`LATENCY`-1; go to BUSY.
- **BUSY:**
  - `req_ready`=0. `req_valid` and all request inputs are ignored.
  - If `cnt`!=0: decrement.
  - If `cnt`==0: perform the access at the next edge and go to RESP.
- **Access**, performed at the BUSY→RESP edge using the captured request:
  - Word, `addr[1:0]`!=0: error. Array is unchanged; `resp_rdata`<=0; `resp_err`<=1.
  - Word store: whole word written.
  - Byte store: only lane `addr[1:0]` is written (little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24]). Other lanes are preserved.
  - Word load: `resp_rdata`<=word.
  - Byte load: `resp_rdata`<={24'b0, selected lane}. Zero-extended; sign extension belongs to the core.
  - All stores: `resp_rdata`<=0.
- **RESP:**
  - `resp_valid`=1 for exactly this cycle; `req_ready`=0.
  - Next edge returns to IDLE unconditionally. There is no response backpressure.
- `resp_rdata` and `resp_err` hold their values until the next access edge; the bench only checks them when `resp_valid`=1.
- Reset is not applied to the array; contents after reset are undefined until written. There is no preload.

## Timing
- Request accepted at edge k.
  - `resp_valid` is high between edges k+`LATENCY` and k+`LATENCY`+1.
  - `req_ready` is high again after edge k+`LATENCY`+1.
  - Minimum request spacing is `LATENCY`+2 cycles.
- A store accepted at k is visible to any load accepted at or after edge k+`LATENCY`+2; no forwarding is needed.
- Reset values (asynchronous, immediate on `reset`=1):
  - state = IDLE, `cnt`=0
  - `req_ready`=1 once `reset` deasserts (0 while `reset` is high)
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0
- Reset during BUSY: the captured request is discarded and a pending store is not performed.
- Reset during RESP: the response pulse is cut off immediately. The store already performed stays written.
- Holding `req_valid` high continuously gives back-to-back requests, accepted at every IDLE cycle.
- `req_valid` dropping while in BUSY has no effect on the in-flight request.

## Test plan
- **Word store then load** (`LATENCY`=2): store 0xDEADBEEF @0x10, then load word @0x10.
  - `resp_valid` arrives 2 cycles after each accept.
  - The load returns 0xDEADBEEF with `resp_err`=0.
- **Byte merge:** store word 0x11223344 @0x20, then store byte 0xAA @0x22.
  - Load word @0x20 returns 0x11AA3344.
  - Load byte @0x23 returns 0x00000011.
- **Misaligned word:** store 0x12345678 @0x06.
  - `resp_err`=1; words @0x04 and @0x08 are unchanged.
  - Byte load @0x06 still succeeds with `resp_err`=0.
- **Reset mid-BUSY:** write 0x0 @0x30. Issue store 0xCAFEF00D @0x30, assert `reset` in the BUSY cycle, then release it.
  - `resp_valid` never pulses; `req_ready` returns to 1.
  - Load @0x30 returns 0x0.
- **Back-to-back with `req_valid` held high** (`LATENCY`=1): four loads.
  - Accepts are exactly 3 cycles apart; each gives exactly one `resp_valid` pulse.
  - Inputs changed while in BUSY have no effect.
- **Address wrap** (`DEPTH_WORDS`=64): store 0x55 @0x100, then load word @0x000.
  - Returns 0x00000055.
